// File: rtl/mod_updown_counter_ld_if.sv
// Control/status bundle for the modulo up/down counter: the counter sees the
// slave view, whatever drives it (the next stage, a controller, a bench) sees the master view.
interface mod_updown_counter_ld_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clr_i;
  logic             ld_i;
  logic [WIDTH-1:0] I_i;
  logic             cnt_i;
  logic             up_i;
  logic             cen_i;
  logic [WIDTH-1:0] A_o;
  logic             tc_o;
  logic             wrap_o;
  logic             ld_err_o;

  modport master (
    output clr_i, ld_i, I_i, cnt_i, up_i, cen_i,
    input  A_o, tc_o, wrap_o, ld_err_o
  );

  modport slave (
    input  clr_i, ld_i, I_i, cnt_i, up_i, cen_i,
    output A_o, tc_o, wrap_o, ld_err_o
  );
endinterface

// File: rtl/mod_updown_counter_ld.sv
// WIDTH-bit modulo-MODULUS up/down counter with clear, range-checked load,
// cascade enable / terminal count, and registered wrap and load-error pulses.
module mod_updown_counter_ld #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mod_updown_counter_ld_if.slave bus
);

  // MODULUS may equal 2**WIDTH, so the top value is formed at 64 bits and
  // then narrowed; every runtime compare stays WIDTH bits wide.
  localparam logic [WIDTH-1:0] MAX_C     = WIDTH'(MODULUS - 64'd1);
  localparam bit               FULL_MOD  = (MODULUS == (64'd1 << WIDTH));

  logic [WIDTH-1:0] a_q, a_d;
  logic             wrap_q, wrap_d;
  logic             ld_err_q, ld_err_d;
  logic             at_max, at_zero, ld_ok, cnt_en;

  assign at_max  = (a_q == MAX_C);
  assign at_zero = (a_q == '0);
  assign ld_ok   = FULL_MOD || (bus.I_i <= MAX_C);
  assign cnt_en  = bus.cnt_i & bus.cen_i;

  always_comb begin
    a_d      = a_q;
    wrap_d   = 1'b0;
    ld_err_d = 1'b0;
    if (bus.clr_i) begin
      a_d = '0;
    end else if (bus.ld_i) begin
      if (ld_ok) a_d = bus.I_i;
      else       ld_err_d = 1'b1;
    end else if (cnt_en) begin
      if (bus.up_i) begin
        if (at_max) begin
          a_d    = '0;
          wrap_d = 1'b1;
        end else begin
          a_d = a_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          a_d    = MAX_C;
          wrap_d = 1'b1;
        end else begin
          a_d = a_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q      <= '0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  // Terminal count ignores clr/ld so a cascade clears and loads all stages together.
  assign bus.tc_o     = cnt_en & (bus.up_i ? at_max : at_zero);
  assign bus.A_o      = a_q;
  assign bus.wrap_o   = wrap_q;
  assign bus.ld_err_o = ld_err_q;

endmodule

// File: doc/mod_updown_counter_ld.md
Name: mod_updown_counter_ld

Overview:
Parametrised successor to the team's 4-bit loadable binary counter. It is a WIDTH-bit modulo-MODULUS up/down counter with synchronous clear, range-checked parallel load, and a cascade enable with terminal-count output, so several instances chain into multi-digit counters (e.g. BCD).
It also provides a registered wrap pulse and a load-error flag. It is used as a timer and sequence-counter primitive in the datapath exercises.

Parameters:
WIDTH, 4, counter register width in bits; legal range 1..32.
MODULUS, 16, count modulus; legal range 2 <= MODULUS <= 2**WIDTH; the count sequence is 0..MODULUS-1.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  asynchronous reset, active-high.
clr_i  input  1  synchronous clear to 0.
ld_i  input  1  synchronous parallel load of I_i.
I_i  input  WIDTH  parallel load value.
cnt_i  input  1  count request.
up_i  input  1  direction: 1 = up, 0 = down.
cen_i  input  1  cascade enable; tie to 1 for a standalone instance, or to the lower stage's tc_o.
A_o  output  WIDTH  current count (registered).
tc_o  output  1  terminal count (combinational).
wrap_o  output  1  registered one-cycle pulse marking a wrap.
ld_err_o  output  1  registered one-cycle pulse marking a rejected load.

Behaviour:
- Reset: while rst_i=1, asynchronously A_o=0, wrap_o=0, ld_err_o=0. The release of rst_i takes effect on the next rising edge.
- Per-edge priority is clr_i > ld_i > count > hold.
- clr_i=1:
  - A_o<=0, wrap_o<=0, ld_err_o<=0.
  - ld_i and cnt_i are ignored that cycle.
- ld_i=1 (clr_i=0):
  - If I_i < MODULUS: A_o<=I_i, ld_err_o<=0.
  - Else: A_o holds and ld_err_o<=1.
  - wrap_o<=0. cnt_i is ignored.
- Count, when clr_i=0, ld_i=0, cnt_i=1 and cen_i=1:
  - Up, at A_o==MODULUS-1: A_o<=0, wrap_o<=1.
  - Up, otherwise: A_o<=A_o+1, wrap_o<=0.
  - Down, at A_o==0: A_o<=MODULUS-1, wrap_o<=1.
  - Down, otherwise: A_o<=A_o-1, wrap_o<=0.
  - ld_err_o<=0.
- Hold (no clear, load or enabled count): A_o unchanged, wrap_o<=0, ld_err_o<=0.
- wrap_o and ld_err_o are single-cycle pulses asserted the cycle after the causing edge. They never stick.
- tc_o = cnt_i & cen_i & (up_i ? A_o==MODULUS-1 : A_o==0).
  - Purely combinational from the current state and inputs; no registered delay.
  - It is 1 exactly when the next edge will wrap, unless clr_i or ld_i overrides.
  - It does not depend on clr_i/ld_i, so cascades load and clear every stage in parallel.
- Cascade: stage k+1 takes cen_i = tc_o of stage k, with cnt_i and up_i shared. This gives a correct multi-digit count with no extra latency.
- Arithmetic: all internal compares and increments are done at WIDTH bits.
  - When MODULUS==2**WIDTH, the wrap compare constant is 2**WIDTH-1; no WIDTH+1-bit overflow is relied on.
- Direction change takes effect on the same edge: up_i is sampled at each counting edge, with no pipeline.
- Reset mid-count: rst_i asserted asynchronously forces 0 at once, regardless of any pending load or count.
- Loads of MODULUS-1 followed by an up count must wrap normally.

Test Plan:
- Reset and clear (WIDTH=4, MODULUS=10): assert rst_i with no clock edge -> A_o=0, wrap_o=0, ld_err_o=0 immediately. From A_o=5, set clr_i=1 together with ld_i=1, I_i=7 -> A_o=0 after the edge.
- Up-count wrap (MODULUS=10): from 0, hold cnt_i=1, up_i=1 for 10 edges -> A_o goes 1..9 then 0. tc_o=1 only while A_o=9. wrap_o=1 for exactly one cycle after the 9->0 edge.
- Down-count and direction change: load 2, set up_i=0 for 3 edges -> 1, 0, 9, with wrap_o pulsing after 0->9. Then set up_i=1 for one edge -> 0.
- Load range check: ld_i=1, I_i=12 with MODULUS=10 -> A_o held, ld_err_o pulses once. I_i=9 -> A_o=9, ld_err_o=0. ld_i and cnt_i both 1 -> load wins.
- Cascade (two instances, MODULUS=10): count up from 00 for 100 edges -> the pair reads 99 after 99 edges and 00 after 100. The upper stage's wrap_o pulses once at the 99->00 transition.
- Full-range edge (WIDTH=4, MODULUS=16, cen_i=0 then 1): with cen_i=0 and cnt_i=1 -> A_o holds and tc_o=0. With cen_i=1 from 15 -> A_o=0 and wrap_o pulses; no X or overflow.
